// File: rtl/ttt_game_ctrl_if.sv
// Player and AI handshake bundle for the tic-tac-toe turn sequencer.
// slave is the controller's view; master is the player front-end plus ai_agent.
interface ttt_game_ctrl_if;
    logic        player_valid;
    logic [3:0]  player_cell;
    logic        player_ready;
    logic        move_err;
    logic        ai_start;
    logic [17:0] ai_board;
    logic        ai_done;
    logic [3:0]  ai_cell;

    modport slave (
        input  player_valid, player_cell, ai_done, ai_cell,
        output player_ready, move_err, ai_start, ai_board
    );

    modport master (
        output player_valid, player_cell, ai_done, ai_cell,
        input  player_ready, move_err, ai_start, ai_board
    );
endinterface

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns the board, validates X moves, drives the AI
// handshake with a timeout, and detects win/draw after every move.
module ttt_game_ctrl #(
    parameter int AI_TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           new_game,
    ttt_game_ctrl_if.slave bus,
    output logic [17:0]    board,
    output logic [1:0]     status,
    output logic           game_over,
    output logic           ai_fault
);
    typedef enum logic [2:0] {
        WAIT_PLAYER,
        CHECK_P,
        AI_START,
        AI_WAIT,
        CHECK_AI,
        GAME_OVER
    } state_t;

    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] MARK_X = 2'b01;
    localparam logic [1:0] MARK_O = 2'b10;
    localparam logic [7:0] WAIT_LIMIT = 8'(AI_TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       move_err_q;
    logic       ai_start_q;

    // Cell k lives at bits [17-2k:16-2k], i.e. shifted down by 16-2k.
    function automatic logic [1:0] get_cell(input logic [17:0] b, input logic [3:0] k);
        logic [1:0] c;
        c = EMPTY;
        for (int i = 0; i < 9; i++)
            if (k == 4'(i)) c = 2'(b >> (16 - 2 * i));
        return c;
    endfunction

    function automatic logic [17:0] set_cell(input logic [17:0] b, input logic [3:0] k,
                                             input logic [1:0] code);
        logic [17:0] r;
        r = b;
        for (int i = 0; i < 9; i++)
            if (k == 4'(i))
                r = (r & ~(18'h3 << (16 - 2 * i))) | (18'(code) << (16 - 2 * i));
        return r;
    endfunction

    function automatic logic line_won(input logic [17:0] b, input logic [1:0] code);
        logic [8:0] m;
        for (int i = 0; i < 9; i++)
            m[i] = (2'(b >> (16 - 2 * i)) == code);
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    function automatic logic board_full(input logic [17:0] b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (2'(b >> (16 - 2 * i)) == EMPTY) full = 1'b0;
        return full;
    endfunction

    assign bus.player_ready = (state == WAIT_PLAYER);
    assign bus.move_err     = move_err_q;
    assign bus.ai_start     = ai_start_q;
    assign bus.ai_board     = board;
    assign game_over        = (state == GAME_OVER);

    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            state      <= WAIT_PLAYER;
            board      <= '0;
            status     <= 2'b00;
            ai_fault   <= 1'b0;
            wait_cnt   <= '0;
            move_err_q <= 1'b0;
            ai_start_q <= 1'b0;
        end else begin
            move_err_q <= 1'b0;
            ai_start_q <= 1'b0;
            case (state)
                WAIT_PLAYER: begin
                    if (bus.player_valid) begin
                        if (bus.player_cell > 4'd8 || get_cell(board, bus.player_cell) != EMPTY) begin
                            move_err_q <= 1'b1;
                        end else begin
                            board <= set_cell(board, bus.player_cell, MARK_X);
                            state <= CHECK_P;
                        end
                    end
                end
                CHECK_P: begin
                    if (line_won(board, MARK_X)) begin
                        status <= 2'b01;
                        state  <= GAME_OVER;
                    end else if (board_full(board)) begin
                        status <= 2'b11;
                        state  <= GAME_OVER;
                    end else begin
                        ai_start_q <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= AI_START;
                    end
                end
                AI_START: begin
                    wait_cnt <= '0;
                    state    <= AI_WAIT;
                end
                // An illegal AI answer and a timeout both end the game with status still 00.
                AI_WAIT: begin
                    if (bus.ai_done) begin
                        if (bus.ai_cell <= 4'd8 && get_cell(board, bus.ai_cell) == EMPTY) begin
                            board <= set_cell(board, bus.ai_cell, MARK_O);
                            state <= CHECK_AI;
                        end else begin
                            ai_fault <= 1'b1;
                            state    <= GAME_OVER;
                        end
                    end else if (wait_cnt == WAIT_LIMIT) begin
                        ai_fault <= 1'b1;
                        state    <= GAME_OVER;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                CHECK_AI: begin
                    if (line_won(board, MARK_O)) begin
                        status <= 2'b10;
                        state  <= GAME_OVER;
                    end else if (board_full(board)) begin
                        status <= 2'b11;
                        state  <= GAME_OVER;
                    end else begin
                        state <= WAIT_PLAYER;
                    end
                end
                GAME_OVER: begin
                end
                default: state <= WAIT_PLAYER;
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Self-checking bench for ttt_game_ctrl: directed scenarios plus random games
// checked against a cell-array game model.
module tb_ttt_game_ctrl;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        new_game;
    logic [17:0] board;
    logic [1:0]  status;
    logic        game_over;
    logic        ai_fault;

    ttt_game_ctrl_if bus();

    ttt_game_ctrl #(.AI_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .bus(bus),
        .board(board), .status(status), .game_over(game_over), .ai_fault(ai_fault)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_pulses = 0;

    always @(posedge clk) if (bus.ai_start === 1'b1) start_pulses++;

    // Game model: 0 empty, 1 X, 2 O.
    int m_cells[9];
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic logic [17:0] m_board();
        int acc = 0;
        for (int k = 0; k < 9; k++) acc += m_cells[k] * (1 << (16 - 2 * k));
        return 18'(acc);
    endfunction

    function automatic logic [1:0] m_status();
        int empties = 0;
        for (int l = 0; l < 8; l++) begin
            int a = m_cells[lines[l][0]];
            if (a != 0 && m_cells[lines[l][1]] == a && m_cells[lines[l][2]] == a) return 2'(a);
        end
        for (int k = 0; k < 9; k++) if (m_cells[k] == 0) empties++;
        return (empties == 0) ? 2'b11 : 2'b00;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 9; k++) m_cells[k] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        idle(1);
        new_game = 1'b0;
        m_clear();
    endtask

    task automatic player_move(input int c);
        bus.player_valid = 1'b1;
        bus.player_cell  = 4'(c);
        idle(1);
        bus.player_valid = 1'b0;
    endtask

    // Alternating X/O sequence with the AI answering on its first AI_WAIT cycle.
    task automatic play_moves(input int mv[9], input int n);
        for (int i = 0; i < n; i++) begin
            if (i % 2 == 0) begin
                player_move(mv[i]);
                m_cells[mv[i]] = 1;
                idle(1);
            end else begin
                idle(1);
                bus.ai_done = 1'b1;
                bus.ai_cell = 4'(mv[i]);
                idle(1);
                bus.ai_done = 1'b0;
                m_cells[mv[i]] = 2;
                idle(1);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (board !== 18'h0) $display("[TB] FAIL reset_board: got %h want 0", board); else pass_cnt++;
        total_cnt++; if (bus.ai_board !== 18'h0) $display("[TB] FAIL reset_ai_board: got %h want 0", bus.ai_board); else pass_cnt++;
        total_cnt++; if (status !== 2'b00) $display("[TB] FAIL reset_status: got %b want 00", status); else pass_cnt++;
        total_cnt++; if (game_over !== 1'b0) $display("[TB] FAIL reset_game_over: got %b want 0", game_over); else pass_cnt++;
        total_cnt++; if (ai_fault !== 1'b0) $display("[TB] FAIL reset_ai_fault: got %b want 0", ai_fault); else pass_cnt++;
        total_cnt++; if (bus.move_err !== 1'b0) $display("[TB] FAIL reset_move_err: got %b want 0", bus.move_err); else pass_cnt++;
        total_cnt++; if (bus.ai_start !== 1'b0) $display("[TB] FAIL reset_ai_start: got %b want 0", bus.ai_start); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1) $display("[TB] FAIL reset_player_ready: got %b want 1", bus.player_ready); else pass_cnt++;
    endtask

    task automatic test_first_move();
        player_move(4);
        m_cells[4] = 1;
        total_cnt++; if (board !== 18'h00100) $display("[TB] FAIL first_board: got %h want 00100", board); else pass_cnt++;
        total_cnt++; if (bus.ai_start !== 1'b0) $display("[TB] FAIL first_start_early: got %b want 0", bus.ai_start); else pass_cnt++;
        idle(1);
        total_cnt++; if (bus.ai_start !== 1'b1) $display("[TB] FAIL first_start_pulse: got %b want 1", bus.ai_start); else pass_cnt++;
        idle(1);
        total_cnt++; if (bus.ai_start !== 1'b0) $display("[TB] FAIL first_start_width: got %b want 0", bus.ai_start); else pass_cnt++;
        bus.ai_done = 1'b1;
        bus.ai_cell = 4'd0;
        idle(1);
        bus.ai_done = 1'b0;
        m_cells[0] = 2;
        total_cnt++; if (board !== 18'h20100) $display("[TB] FAIL first_ai_board: got %h want 20100", board); else pass_cnt++;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL first_model_board: got %h want %h", board, m_board()); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b0) $display("[TB] FAIL first_ready_early: got %b want 0", bus.player_ready); else pass_cnt++;
        idle(1);
        total_cnt++; if (bus.player_ready !== 1'b1) $display("[TB] FAIL first_ready: got %b want 1", bus.player_ready); else pass_cnt++;
    endtask

    task automatic test_move_err();
        int s = start_pulses;
        bus.player_valid = 1'b1;
        bus.player_cell  = 4'd4;
        idle(1);
        total_cnt++; if (bus.move_err !== 1'b1) $display("[TB] FAIL err_occupied: got %b want 1", bus.move_err); else pass_cnt++;
        bus.player_cell = 4'd9;
        idle(1);
        total_cnt++; if (bus.move_err !== 1'b1) $display("[TB] FAIL err_range: got %b want 1", bus.move_err); else pass_cnt++;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL err_board: got %h want %h", board, m_board()); else pass_cnt++;
        bus.player_valid = 1'b0;
        idle(1);
        total_cnt++; if (bus.move_err !== 1'b0) $display("[TB] FAIL err_clear: got %b want 0", bus.move_err); else pass_cnt++;
        idle(3);
        total_cnt++; if (start_pulses !== s) $display("[TB] FAIL err_no_start: got %0d want %0d", start_pulses, s); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1) $display("[TB] FAIL err_ready: got %b want 1", bus.player_ready); else pass_cnt++;
    endtask

    task automatic test_x_win();
        int mv[9] = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
        int s;
        do_new_game();
        s = start_pulses;
        play_moves(mv, 5);
        total_cnt++; if (status !== 2'b01 || status !== m_status()) $display("[TB] FAIL xwin_status: got %b want 01", status); else pass_cnt++;
        total_cnt++; if (game_over !== 1'b1) $display("[TB] FAIL xwin_over: got %b want 1", game_over); else pass_cnt++;
        total_cnt++; if (start_pulses - s !== 2) $display("[TB] FAIL xwin_starts: got %0d want 2", start_pulses - s); else pass_cnt++;
        bus.player_valid = 1'b1;
        bus.player_cell  = 4'd5;
        idle(2);
        bus.player_valid = 1'b0;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL xwin_hold_board: got %h want %h", board, m_board()); else pass_cnt++;
        total_cnt++; if (bus.move_err !== 1'b0) $display("[TB] FAIL xwin_no_err: got %b want 0", bus.move_err); else pass_cnt++;
        total_cnt++; if (game_over !== 1'b1 || status !== 2'b01) $display("[TB] FAIL xwin_hold: got %b/%b want 1/01", game_over, status); else pass_cnt++;
    endtask

    task automatic test_o_win();
        int mv[9] = '{0, 4, 8, 2, 1, 6, 0, 0, 0};
        do_new_game();
        play_moves(mv, 6);
        total_cnt++; if (status !== 2'b10 || status !== m_status()) $display("[TB] FAIL owin_status: got %b want 10", status); else pass_cnt++;
        total_cnt++; if (game_over !== 1'b1) $display("[TB] FAIL owin_over: got %b want 1", game_over); else pass_cnt++;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL owin_board: got %h want %h", board, m_board()); else pass_cnt++;
    endtask

    task automatic test_draw();
        int mv[9] = '{0, 4, 2, 1, 7, 3, 5, 8, 6};
        int s;
        do_new_game();
        s = start_pulses;
        play_moves(mv, 9);
        total_cnt++; if (status !== 2'b11 || status !== m_status()) $display("[TB] FAIL draw_status: got %b want 11", status); else pass_cnt++;
        total_cnt++; if (game_over !== 1'b1) $display("[TB] FAIL draw_over: got %b want 1", game_over); else pass_cnt++;
        total_cnt++; if (start_pulses - s !== 4) $display("[TB] FAIL draw_starts: got %0d want 4", start_pulses - s); else pass_cnt++;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL draw_board: got %h want %h", board, m_board()); else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cyc = 0;
        do_new_game();
        player_move(4);
        m_cells[4] = 1;
        while (game_over !== 1'b1 && cyc < 300) begin
            idle(1);
            cyc++;
        end
        total_cnt++; if (cyc < T + 1 || cyc > T + 2) $display("[TB] FAIL timeout_latency: got %0d cycles want %0d..%0d", cyc, T + 1, T + 2); else pass_cnt++;
        total_cnt++; if (ai_fault !== 1'b1) $display("[TB] FAIL timeout_fault: got %b want 1", ai_fault); else pass_cnt++;
        total_cnt++; if (status !== 2'b00) $display("[TB] FAIL timeout_status: got %b want 00", status); else pass_cnt++;
        bus.ai_done = 1'b1;
        bus.ai_cell = 4'd0;
        idle(2);
        bus.ai_done = 1'b0;
        total_cnt++; if (board !== m_board()) $display("[TB] FAIL timeout_late_done: got %h want %h", board, m_board()); else pass_cnt++;
        total_cnt++; if (ai_fault !== 1'b1 || game_over !== 1'b1) $display("[TB] FAIL timeout_hold: got %b/%b want 1/1", ai_fault, game_over); else pass_cnt++;
        do_new_game();
        total_cnt++; if (board !== 18'h0 || status !== 2'b00) $display("[TB] FAIL newgame_clear: got %h/%b want 0/00", board, status); else pass_cnt++;
        total_cnt++; if (ai_fault !== 1'b0) $display("[TB] FAIL newgame_fault: got %b want 0", ai_fault); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1 || game_over !== 1'b0) $display("[TB] FAIL newgame_ready: got %b/%b want 1/0", bus.player_ready, game_over); else pass_cnt++;
    endtask

    task automatic test_new_game_in_wait();
        player_move(0);
        idle(4);
        new_game     = 1'b1;
        bus.ai_done  = 1'b1;
        bus.ai_cell  = 4'd1;
        idle(1);
        new_game = 1'b0;
        m_clear();
        total_cnt++; if (board !== 18'h0) $display("[TB] FAIL ngwait_board: got %h want 0", board); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1) $display("[TB] FAIL ngwait_ready: got %b want 1", bus.player_ready); else pass_cnt++;
        idle(1);
        bus.ai_done = 1'b0;
        total_cnt++; if (board !== 18'h0 || ai_fault !== 1'b0) $display("[TB] FAIL ngwait_stale: got %h/%b want 0/0", board, ai_fault); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1 || status !== 2'b00) $display("[TB] FAIL ngwait_state: got %b/%b want 1/00", bus.player_ready, status); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        player_move(2);
        idle(3);
        do_reset();
        bus.ai_done = 1'b1;
        bus.ai_cell = 4'd5;
        idle(2);
        bus.ai_done = 1'b0;
        total_cnt++; if (board !== 18'h0 || ai_fault !== 1'b0) $display("[TB] FAIL rstmid_board: got %h/%b want 0/0", board, ai_fault); else pass_cnt++;
        total_cnt++; if (bus.player_ready !== 1'b1 || game_over !== 1'b0) $display("[TB] FAIL rstmid_state: got %b/%b want 1/0", bus.player_ready, game_over); else pass_cnt++;
    endtask

    // Random games: random (sometimes illegal) X moves, random AI delay, occasional illegal AI cell.
    task automatic test_random_games(input int games);
        for (int g = 0; g < games; g++) begin
            bit over = 1'b0;
            int tries = 0;
            do_new_game();
            while (!over && tries < 40) begin
                int pc = int'($urandom_range(0, 11));
                bit legal = (pc <= 8) ? (m_cells[pc] == 0) : 1'b0;
                logic [1:0] exp;
                tries++;
                player_move(pc);
                if (!legal) begin
                    total_cnt++; if (bus.move_err !== 1'b1 || board !== m_board()) $display("[TB] FAIL rnd_reject: err %b board %h want 1 %h", bus.move_err, board, m_board()); else pass_cnt++;
                end else begin
                    m_cells[pc] = 1;
                    total_cnt++; if (board !== m_board()) $display("[TB] FAIL rnd_x_board: got %h want %h", board, m_board()); else pass_cnt++;
                    idle(1);
                    exp = m_status();
                    total_cnt++; if (status !== exp || game_over !== (exp != 2'b00)) $display("[TB] FAIL rnd_x_status: got %b/%b want %b/%b", status, game_over, exp, exp != 2'b00); else pass_cnt++;
                    if (exp != 2'b00) begin
                        over = 1'b1;
                    end else begin
                        int ac;
                        bit bad = ($urandom_range(0, 9) == 0);
                        int q[$];
                        total_cnt++; if (bus.ai_start !== 1'b1) $display("[TB] FAIL rnd_ai_start: got %b want 1", bus.ai_start); else pass_cnt++;
                        idle(1);
                        idle(int'($urandom_range(0, 4)));
                        for (int k = 0; k < 9; k++) if (m_cells[k] == 0) q.push_back(k);
                        if (bad) ac = ($urandom_range(0, 1) == 1) ? pc : 9 + int'($urandom_range(0, 6));
                        else ac = q[$urandom_range(0, q.size() - 1)];
                        bus.ai_done = 1'b1;
                        bus.ai_cell = 4'(ac);
                        idle(1);
                        bus.ai_done = 1'b0;
                        if (bad) begin
                            total_cnt++; if (ai_fault !== 1'b1 || game_over !== 1'b1 || status !== 2'b00) $display("[TB] FAIL rnd_ai_illegal: got %b/%b/%b want 1/1/00", ai_fault, game_over, status); else pass_cnt++;
                            total_cnt++; if (board !== m_board()) $display("[TB] FAIL rnd_ai_illegal_board: got %h want %h", board, m_board()); else pass_cnt++;
                            over = 1'b1;
                        end else begin
                            m_cells[ac] = 2;
                            total_cnt++; if (board !== m_board()) $display("[TB] FAIL rnd_o_board: got %h want %h", board, m_board()); else pass_cnt++;
                            idle(1);
                            exp = m_status();
                            total_cnt++; if (status !== exp || game_over !== (exp != 2'b00)) $display("[TB] FAIL rnd_o_status: got %b/%b want %b/%b", status, game_over, exp, exp != 2'b00); else pass_cnt++;
                            if (exp != 2'b00) over = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        new_game         = 1'b0;
        bus.player_valid = 1'b0;
        bus.player_cell  = 4'd0;
        bus.ai_done      = 1'b0;
        bus.ai_cell      = 4'd0;
        idle(2);
        test_reset();
        test_first_move();
        test_move_err();
        test_x_win();
        test_o_win();
        test_draw();
        test_timeout();
        test_new_game_in_wait();
        test_rst_mid();
        test_random_games(20);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
